// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response and decode-side handshake bundle
interface fetch_if #(parameter int DATA_WIDTH = 32);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  PCsrc;
  logic [DATA_WIDTH-1:0] PCtarget;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  modport master (
    output imem_req, imem_addr, instr, instr_pc, pc_plus4, instr_valid,
    input  imem_rvalid, imem_rdata, instr_ready, PCsrc, PCtarget, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, pc_plus4, instr_valid,
    output imem_rvalid, imem_rdata, instr_ready, PCsrc, PCtarget, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with branch/redirect handling and stale-response kill
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);
  typedef enum logic [1:0] {RST, FETCH, WAIT, HOLD} state_t;
  localparam logic [DATA_WIDTH-1:0] ALIGN = ~DATA_WIDTH'(3);
  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic                  kill;
  assign bus.imem_req  = state == FETCH;
  assign bus.imem_addr = state == FETCH ? pc : '0;
  assign bus.pc_plus4  = bus.instr_pc + DATA_WIDTH'(4);
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RST;
      pc              <= RESET_PC & ALIGN;
      kill            <= 1'b0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
    end else begin
      case (state)
        RST: state <= FETCH;
        FETCH: begin
          state <= WAIT;
          if (bus.redirect_valid) begin
            pc   <= bus.redirect_pc & ALIGN;
            kill <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.redirect_valid) pc <= bus.redirect_pc & ALIGN;
          // a response arriving alongside a redirect is already stale
          if (bus.imem_rvalid) begin
            kill <= 1'b0;
            if (kill || bus.redirect_valid) state <= FETCH;
            else begin
              bus.instr       <= bus.imem_rdata;
              bus.instr_pc    <= pc;
              bus.instr_valid <= 1'b1;
              state           <= HOLD;
            end
          end else if (bus.redirect_valid) kill <= 1'b1;
        end
        HOLD: begin
          if (bus.redirect_valid || bus.instr_ready) begin
            pc <= bus.redirect_valid ? bus.redirect_pc & ALIGN :
                  bus.PCsrc          ? bus.PCtarget & ALIGN    : pc + DATA_WIDTH'(4);
            bus.instr_valid <= 1'b0;
            state           <= FETCH;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run against an architectural next-PC model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_if #(.DATA_WIDTH(32)) bus();
  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int fails  = 0;
  int lat    = 1;
  int cyc    = 0;
  typedef struct { int due; logic [31:0] addr; } req_t;
  req_t q[$];
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  // fixed-latency memory: a request seen in cycle k is answered during cycle k+lat
  initial begin
    req_t r;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        r.due  = cyc + lat;
        r.addr = bus.imem_addr;
        q.push_back(r);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0 && q[0].due == cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_f(q[0].addr);
        void'(q.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask
  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr, bus.instr_pc} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b valid=%b addr=%h instr=%h pc=%h, expected all zero",
               bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr, bus.instr_pc);
    end
    rst = 1'b0;
    n = 1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_cycle_req: got %b expected 0", bus.imem_req);
    end
    while (bus.imem_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n !== 2 || bus.imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_first_req: got cycle %0d addr %h expected cycle 2 addr 00000000", n, bus.imem_addr);
    end
  endtask
  task automatic test_sequential();
    int n;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 4 * i || bus.instr !== mem_f(4 * i) || bus.pc_plus4 !== 4 * i + 4) begin
        fails++;
        $display("FAIL seq_instr%0d: got valid=%b pc=%h instr=%h plus4=%h expected pc=%h instr=%h plus4=%h",
                 i, bus.instr_valid, bus.instr_pc, bus.instr, bus.pc_plus4, 4 * i, mem_f(4 * i), 4 * i + 4);
      end
      if (i > 0) begin
        checks++;
        if (n !== 2) begin
          fails++;
          $display("FAIL seq_interval%0d: got %0d cycles expected 3", i, n + 1);
        end
      end
      step();
    end
    bus.instr_ready = 1'b0;
  endtask
  task automatic test_backpressure();
    int n;
    logic [31:0] si, sp;
    wait_valid(n);
    si = bus.instr;
    sp = bus.instr_pc;
    checks++;
    if (bus.instr_valid !== 1'b1 || sp !== 32'hC) begin
      fails++;
      $display("FAIL bp_present: got valid=%b pc=%h expected valid=1 pc=0000000c", bus.instr_valid, sp);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== si || bus.instr_pc !== sp || bus.imem_req !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: got valid=%b instr=%h pc=%h req=%b expected valid=1 instr=%h pc=%h req=0",
                 i, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req, si, sp);
      end
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== sp + 4) begin
      fails++;
      $display("FAIL bp_next_req: got req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, sp + 4);
    end
  endtask
  task automatic test_branch();
    int n;
    wait_valid(n);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h10) begin
      fails++;
      $display("FAIL br_present: got valid=%b pc=%h expected pc=00000010", bus.instr_valid, bus.instr_pc);
    end
    bus.PCsrc = 1'b1; bus.PCtarget = 32'h40; bus.instr_ready = 1'b1;
    step();
    bus.PCsrc = 1'b0; bus.instr_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      fails++;
      $display("FAIL br_target: got req=%b addr=%h expected addr=00000040", bus.imem_req, bus.imem_addr);
    end
    wait_valid(n);
    checks++;
    if (bus.instr_pc !== 32'h40 || bus.instr !== mem_f(32'h40)) begin
      fails++;
      $display("FAIL br_instr: got pc=%h instr=%h expected pc=00000040 instr=%h", bus.instr_pc, bus.instr, mem_f(32'h40));
    end
    bus.PCsrc = 1'b1; bus.PCtarget = 32'h43; bus.instr_ready = 1'b1;
    step();
    bus.PCsrc = 1'b0; bus.instr_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      fails++;
      $display("FAIL br_align: got req=%b addr=%h expected addr=00000040", bus.imem_req, bus.imem_addr);
    end
  endtask
  task automatic test_redirect_wait();
    int n;
    bit seen;
    wait_valid(n);
    bus.PCsrc = 1'b1; bus.PCtarget = 32'h8; bus.instr_ready = 1'b1;
    step();
    bus.PCsrc = 1'b0; bus.instr_ready = 1'b0;
    lat = 4;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      fails++;
      $display("FAIL rw_req8: got req=%b addr=%h expected addr=00000008", bus.imem_req, bus.imem_addr);
    end
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (bus.imem_req !== 1'b1 && n < 50) begin
      if (bus.instr_valid === 1'b1) seen = 1'b1;
      step();
      n++;
    end
    checks++;
    if (seen || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      fails++;
      $display("FAIL rw_next_req: got stale_seen=%b req=%b addr=%h expected stale_seen=0 addr=00000100",
               seen, bus.imem_req, bus.imem_addr);
    end
    wait_valid(n);
    checks++;
    if (bus.instr_pc !== 32'h100 || bus.instr !== mem_f(32'h100)) begin
      fails++;
      $display("FAIL rw_instr: got pc=%h instr=%h expected pc=00000100 instr=%h", bus.instr_pc, bus.instr, mem_f(32'h100));
    end
  endtask
  task automatic test_redirect_handshake();
    int n;
    lat = 1;
    bus.instr_ready = 1'b1; bus.PCsrc = 1'b1; bus.PCtarget = 32'h20;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    step();
    bus.instr_ready = 1'b0; bus.PCsrc = 1'b0; bus.redirect_valid = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      fails++;
      $display("FAIL rh_req: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000200",
               bus.instr_valid, bus.imem_req, bus.imem_addr);
    end
    wait_valid(n);
    checks++;
    if (bus.instr_pc !== 32'h200) begin
      fails++;
      $display("FAIL rh_instr: got pc=%h expected 00000200", bus.instr_pc);
    end
  endtask
  task automatic test_wrap_reset();
    int n;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (bus.instr_pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0 || bus.instr !== mem_f(32'hFFFF_FFFC)) begin
      fails++;
      $display("FAIL wrap_instr: got pc=%h plus4=%h instr=%h expected pc=fffffffc plus4=00000000 instr=%h",
               bus.instr_pc, bus.pc_plus4, bus.instr, mem_f(32'hFFFF_FFFC));
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL wrap_req: got req=%b addr=%h expected addr=00000000", bus.imem_req, bus.imem_addr);
    end
    wait_valid(n);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    lat = 4;
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr, bus.instr_pc} !== '0 || bus.pc_plus4 !== 32'h4) begin
      fails++;
      $display("FAIL midwait_reset: got req=%b valid=%b addr=%h instr=%h pc=%h plus4=%h expected zeros and plus4=00000004",
               bus.imem_req, bus.instr_valid, bus.imem_addr, bus.instr, bus.instr_pc, bus.pc_plus4);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_refetch: got req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr);
    end
    wait_valid(n);
    checks++;
    if (n !== 5 || bus.instr_pc !== 32'h0 || bus.instr !== mem_f(32'h0)) begin
      fails++;
      $display("FAIL late_rvalid: got %0d cycles pc=%h instr=%h expected 5 cycles pc=00000000 instr=%h",
               n, bus.instr_pc, bus.instr, mem_f(32'h0));
    end
  endtask
  task automatic test_random();
    logic [31:0] exp_pc;
    int hs;
    exp_pc = 32'h0;
    hs = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) lat = $urandom_range(1, 4);
      bus.instr_ready    = ($urandom % 3) != 0;
      bus.PCsrc          = ($urandom % 4) == 0;
      bus.PCtarget       = $urandom;
      bus.redirect_valid = ($urandom % 12) == 0;
      bus.redirect_pc    = $urandom;
      if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~32'h3;
      else if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
        checks++;
        if (bus.instr_pc !== exp_pc || bus.instr !== mem_f(exp_pc) || bus.pc_plus4 !== exp_pc + 4) begin
          fails++;
          $display("FAIL rand_instr@%0d: got pc=%h instr=%h plus4=%h expected pc=%h instr=%h plus4=%h",
                   i, bus.instr_pc, bus.instr, bus.pc_plus4, exp_pc, mem_f(exp_pc), exp_pc + 4);
        end
        exp_pc = bus.PCsrc ? bus.PCtarget & ~32'h3 : exp_pc + 4;
        hs++;
      end
      step();
    end
    bus.instr_ready = 1'b0; bus.PCsrc = 1'b0; bus.redirect_valid = 1'b0;
    checks++;
    if (hs < 20) begin
      fails++;
      $display("FAIL rand_progress: got %0d handshakes expected at least 20", hs);
    end
  endtask
  initial begin
    bus.instr_ready    = 1'b0;
    bus.PCsrc          = 1'b0;
    bus.PCtarget       = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch();
    test_redirect_wait();
    test_redirect_handshake();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
